// File: rtl/data_packer.sv
// data_packer: packs PACK input words into one wide beat, flushing early on last; DATA_PACKER_WORD_CNT_EN adds data_out_cnt
module data_packer #(
    parameter int DATA_IN_W = 32,
    parameter int PACK      = 4,
    parameter int CNT_W     = $clog2(PACK) + 1
) (
    input  logic                      clk,
    input  logic                      nrst,
    input  logic                      en,
    input  logic                      sync_rst,
    input  logic [DATA_IN_W-1:0]      data_in,
    input  logic                      data_in_last,
    input  logic                      data_in_valid,
    output logic                      data_in_ready,
    output logic [DATA_IN_W*PACK-1:0] data_out,
    output logic                      data_out_last,
    output logic                      data_out_valid,
    input  logic                      data_out_ready
`ifdef DATA_PACKER_WORD_CNT_EN
    ,
    output logic [CNT_W-1:0]          data_out_cnt
`endif
);
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK - 1);
    logic [CNT_W-1:0]          word_cnt;
    logic [DATA_IN_W*PACK-1:0] acc;
    logic [DATA_IN_W*PACK-1:0] merged;
    logic                      in_shake;
    logic                      out_shake;
    logic                      complete;
    assign data_in_ready = en & ~sync_rst & (~data_out_valid | data_out_ready);
    assign in_shake      = data_in_valid & data_in_ready;
    assign out_shake     = data_out_valid & data_out_ready;
    assign complete      = in_shake & ((word_cnt == LAST_LANE) | data_in_last);
    // accumulator with the incoming word dropped into lane word_cnt, lanes above it zeroed
    always_comb begin
        merged = '0;
        for (int k = 0; k < PACK; k++)
            merged[k*DATA_IN_W +: DATA_IN_W] = (CNT_W'(k) < word_cnt) ? acc[k*DATA_IN_W +: DATA_IN_W] :
                                               (CNT_W'(k) == word_cnt) ? data_in : '0;
    end
    // word accumulation and output beat register; a completing word may replace a beat being taken
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            word_cnt       <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (sync_rst) begin
            word_cnt       <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_last  <= 1'b0;
            data_out_valid <= 1'b0;
        end else if (complete) begin
            word_cnt       <= '0;
            acc            <= '0;
            data_out       <= merged;
            data_out_last  <= data_in_last;
            data_out_valid <= 1'b1;
        end else begin
            if (in_shake) begin
                word_cnt <= word_cnt + CNT_W'(1);
                acc      <= merged;
            end
            if (out_shake)
                data_out_valid <= 1'b0;
        end
    end
`ifdef DATA_PACKER_WORD_CNT_EN
    // number of populated lanes, loaded alongside data_out
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            data_out_cnt <= '0;
        else if (sync_rst)
            data_out_cnt <= '0;
        else if (complete)
            data_out_cnt <= word_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_data_packer.sv
// tb_data_packer: directed checks of data_packer with PACK=4, DATA_IN_W=32
module tb_data_packer;
    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         en = 1'b1;
    logic         sync_rst = 1'b0;
    logic [31:0]  data_in = '0;
    logic         data_in_last = 1'b0;
    logic         data_in_valid = 1'b0;
    logic         data_in_ready;
    logic [127:0] data_out;
    logic         data_out_last;
    logic         data_out_valid;
    logic         data_out_ready = 1'b1;
`ifdef DATA_PACKER_WORD_CNT_EN
    logic [2:0]   data_out_cnt;
`endif
    int checks = 0;
    int errors = 0;
    logic [127:0] held;

    data_packer #(.DATA_IN_W(32), .PACK(4)) dut (
        .clk(clk), .nrst(nrst), .en(en), .sync_rst(sync_rst),
        .data_in(data_in), .data_in_last(data_in_last), .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready), .data_out(data_out), .data_out_last(data_out_last),
        .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
`ifdef DATA_PACKER_WORD_CNT_EN
        , .data_out_cnt(data_out_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input logic l);
        data_in = w;
        data_in_last = l;
        data_in_valid = 1'b1;
        tick();
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef DATA_PACKER_WORD_CNT_EN
        chk(tag, 128'(data_out_cnt), 128'(exp));
`endif
    endtask

    initial begin
        #2;
        chk("rst_valid", 128'(data_out_valid), 128'(0));
        chk("rst_data", data_out, 128'(0));
        #20 nrst = 1'b1;
        tick();
        chk("idle_ready", 128'(data_in_ready), 128'(1));
        chk("idle_valid", 128'(data_out_valid), 128'(0));
        chk("idle_data", data_out, 128'(0));
        chk("idle_last", 128'(data_out_last), 128'(0));
        chk_cnt("idle_cnt", 0);

        send(32'h11, 1'b0);
        send(32'h22, 1'b0);
        send(32'h33, 1'b0);
        chk("full_pre_valid", 128'(data_out_valid), 128'(0));
        send(32'h44, 1'b1);
        data_in_valid = 1'b0;
        chk("full_valid", 128'(data_out_valid), 128'(1));
        chk("full_data", data_out, {32'h44, 32'h33, 32'h22, 32'h11});
        chk("full_last", 128'(data_out_last), 128'(1));
        chk_cnt("full_cnt", 4);
        tick();
        chk("full_drain", 128'(data_out_valid), 128'(0));

        send(32'hA, 1'b0);
        send(32'hB, 1'b1);
        data_in_valid = 1'b0;
        chk("part_valid", 128'(data_out_valid), 128'(1));
        chk("part_data", data_out, {32'h0, 32'h0, 32'hB, 32'hA});
        chk("part_last", 128'(data_out_last), 128'(1));
        chk_cnt("part_cnt", 2);
        tick();

        data_out_ready = 1'b0;
        send(32'h1, 1'b0);
        send(32'h2, 1'b0);
        send(32'h3, 1'b0);
        send(32'h4, 1'b0);
        data_in = 32'h99;
        data_in_last = 1'b0;
        chk("bp_data", data_out, {32'h4, 32'h3, 32'h2, 32'h1});
        chk("bp_last", 128'(data_out_last), 128'(0));
        held = data_out;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 128'(data_in_ready), 128'(0));
            chk("bp_valid", 128'(data_out_valid), 128'(1));
            chk("bp_hold", data_out, held);
            tick();
        end
        data_out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(data_in_ready), 128'(1));
        tick();
        chk("bp_drained", 128'(data_out_valid), 128'(0));
        send(32'h98, 1'b1);
        data_in_valid = 1'b0;
        chk("bp_next_data", data_out, {32'h0, 32'h0, 32'h98, 32'h99});
        chk_cnt("bp_next_cnt", 2);
        tick();

        for (int i = 1; i <= 8; i++) begin
            chk("b2b_ready", 128'(data_in_ready), 128'(1));
            send(32'(i), i == 8);
            if (i == 4) begin
                chk("b2b_beat1", data_out, {32'h4, 32'h3, 32'h2, 32'h1});
                chk("b2b_beat1_last", 128'(data_out_last), 128'(0));
            end
        end
        data_in_valid = 1'b0;
        chk("b2b_beat2", data_out, {32'h8, 32'h7, 32'h6, 32'h5});
        chk("b2b_beat2_last", 128'(data_out_last), 128'(1));
        chk("b2b_beat2_valid", 128'(data_out_valid), 128'(1));

        for (int i = 0; i < 3; i++) begin
            send(32'hF0 + 32'(i), 1'b1);
            chk("single_valid", 128'(data_out_valid), 128'(1));
            chk("single_data", data_out, 128'(32'hF0 + 32'(i)));
            chk("single_last", 128'(data_out_last), 128'(1));
            chk_cnt("single_cnt", 1);
        end
        data_in_valid = 1'b0;
        tick();

        send(32'hC1, 1'b0);
        send(32'hC2, 1'b0);
        en = 1'b0;
        data_in = 32'hEE;
        data_in_valid = 1'b1;
        #1;
        chk("en_ready", 128'(data_in_ready), 128'(0));
        tick();
        tick();
        chk("en_hold_valid", 128'(data_out_valid), 128'(0));
        en = 1'b1;
        send(32'hC3, 1'b0);
        send(32'hC4, 1'b1);
        data_in_valid = 1'b0;
        chk("en_resume_data", data_out, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
        chk("en_resume_valid", 128'(data_out_valid), 128'(1));
        tick();

        send(32'hD1, 1'b0);
        send(32'hD2, 1'b0);
        data_in_valid = 1'b0;
        sync_rst = 1'b1;
        #1;
        chk("srst_ready", 128'(data_in_ready), 128'(0));
        tick();
        sync_rst = 1'b0;
        chk("srst_data", data_out, 128'(0));
        chk("srst_valid", 128'(data_out_valid), 128'(0));
        send(32'hE1, 1'b0);
        send(32'hE2, 1'b0);
        send(32'hE3, 1'b0);
        send(32'hE4, 1'b0);
        data_in_valid = 1'b0;
        chk("srst_fresh_data", data_out, {32'hE4, 32'hE3, 32'hE2, 32'hE1});
        chk("srst_fresh_last", 128'(data_out_last), 128'(0));
        chk_cnt("srst_fresh_cnt", 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
